// File: rtl/alu_seq16_if.sv
// Bundle of request, ALU-drive and result signals between the CPU control unit, the sequencer and the 8-bit ALU.
// Optional ALU_SEQ_FLAGS_EN adds the res_zero / res_ovf result flags.
interface alu_seq16_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_s0;
    logic        alu_s1;
    logic        alu_s2;
    logic        alu_s3;
    logic        alu_s4;
    logic [7:0]  alu_z;
    logic        alu_cout;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_cout;
    logic        res_err;
`ifdef ALU_SEQ_FLAGS_EN
    logic        res_zero;
    logic        res_ovf;
`endif

    // Sequencer side
    modport slave (
        input  req_valid, req_op, req_a, req_b, alu_z, alu_cout, res_ready,
        output req_ready, alu_a, alu_b, alu_s0, alu_s1, alu_s2, alu_s3, alu_s4,
        output res_valid, res_data, res_cout, res_err
`ifdef ALU_SEQ_FLAGS_EN
        , output res_zero, res_ovf
`endif
    );

    // Requester / ALU side
    modport master (
        output req_valid, req_op, req_a, req_b, alu_z, alu_cout, res_ready,
        input  req_ready, alu_a, alu_b, alu_s0, alu_s1, alu_s2, alu_s3, alu_s4,
        input  res_valid, res_data, res_cout, res_err
`ifdef ALU_SEQ_FLAGS_EN
        , input res_zero, res_ovf
`endif
    );
endinterface

// File: rtl/alu_seq16.sv
// 16-bit operation sequencer over a shared 8-bit combinational ALU: low byte pass, then high byte pass with carry chained.
// Optional macro ALU_SEQ_FLAGS_EN adds registered res_zero and res_ovf outputs.
module alu_seq16 (
    input  logic       clk,
    input  logic       rst,
    alu_seq16_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_AND   = 3'd2;
    localparam logic [2:0] OP_PASSA = 3'd3;
    localparam logic [2:0] OP_PASSB = 3'd4;
    localparam logic [2:0] OP_INC   = 3'd5;
    localparam logic [2:0] OP_DEC   = 3'd6;
    localparam logic [2:0] OP_ILL   = 3'd7;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_op;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic        r_carry;
    logic [15:0] r_res_data;
    logic        r_res_cout;
    logic        r_res_err;
    logic [7:0]  w_alu_a;
    logic [7:0]  w_alu_b;
    logic [4:0]  w_sel;
    logic [7:0]  w_z;
    logic        w_arith;
`ifdef ALU_SEQ_FLAGS_EN
    logic        r_res_zero;
    logic        r_res_ovf;
`endif

    function automatic logic f_is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_INC) || (op == OP_DEC);
    endfunction

    // Select word {s4,s3,s2,s1,s0}; the high pass takes the carry from the low pass as s2.
    function automatic logic [4:0] f_sel(input logic [2:0] op, input logic hi, input logic c);
        logic [4:0] sel;
        case (op)
            OP_ADD:   sel = {1'b0, 1'b0, (hi ? c : 1'b0), 2'b00};
            OP_SUB:   sel = {1'b0, 1'b1, (hi ? c : 1'b1), 2'b00};
            OP_AND:   sel = 5'b00_0_01;
            OP_PASSA: sel = 5'b00_0_10;
            OP_PASSB: sel = 5'b00_0_11;
            OP_INC:   sel = {1'b1, 1'b0, (hi ? c : 1'b1), 2'b00};
            OP_DEC:   sel = {1'b0, 1'b0, (hi ? c : 1'b0), 2'b00};
            default:  sel = 5'b10_0_00;
        endcase
        return sel;
    endfunction

    // Signed overflow from the sign bits of the effective operands and the result.
    function automatic logic f_ovf(input logic [2:0] op, input logic sa, input logic sb, input logic sr);
        logic sbe;
        case (op)
            OP_ADD:  sbe = sb;
            OP_SUB:  sbe = ~sb;
            OP_INC:  sbe = 1'b0;
            OP_DEC:  sbe = 1'b1;
            default: sbe = 1'b0;
        endcase
        return f_is_arith(op) && (sa == sbe) && (sr != sa);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_alu_a = 8'h00;
        w_alu_b = 8'h00;
        w_sel   = 5'b00000;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    w_next = ST_LO;
                end
            end
            ST_LO: begin
                w_alu_a = r_a[7:0];
                w_alu_b = (r_op == OP_DEC) ? 8'hFF : r_b[7:0];
                w_sel   = f_sel(r_op, 1'b0, r_carry);
                w_next  = ST_HI;
            end
            ST_HI: begin
                w_alu_a = r_a[15:8];
                w_alu_b = (r_op == OP_DEC) ? 8'hFF : r_b[15:8];
                w_sel   = f_sel(r_op, 1'b1, r_carry);
                w_next  = ST_DONE;
            end
            ST_DONE: begin
                if (bus.res_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_z     = (r_op == OP_ILL) ? 8'h00 : bus.alu_z;
    assign w_arith = f_is_arith(r_op);

    // Request latch and per-pass result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op       <= 3'd0;
            r_a        <= 16'h0000;
            r_b        <= 16'h0000;
            r_carry    <= 1'b0;
            r_res_data <= 16'h0000;
            r_res_cout <= 1'b0;
            r_res_err  <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
            r_res_zero <= 1'b0;
            r_res_ovf  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_op <= bus.req_op;
                        r_a  <= bus.req_a;
                        r_b  <= bus.req_b;
                    end
                end
                ST_LO: begin
                    r_res_data[7:0] <= w_z;
                    r_carry         <= bus.alu_cout;
                end
                ST_HI: begin
                    r_res_data[15:8] <= w_z;
                    r_res_cout       <= w_arith & bus.alu_cout;
                    r_res_err        <= (r_op == OP_ILL);
`ifdef ALU_SEQ_FLAGS_EN
                    r_res_zero <= ({w_z, r_res_data[7:0]} == 16'h0000);
                    r_res_ovf  <= f_ovf(r_op, r_a[15], r_b[15], w_z[7]);
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = (r_state == ST_IDLE) && !rst;
    assign bus.res_valid = (r_state == ST_DONE);
    assign bus.alu_a     = w_alu_a;
    assign bus.alu_b     = w_alu_b;
    assign bus.alu_s0    = w_sel[0];
    assign bus.alu_s1    = w_sel[1];
    assign bus.alu_s2    = w_sel[2];
    assign bus.alu_s3    = w_sel[3];
    assign bus.alu_s4    = w_sel[4];
    assign bus.res_data  = r_res_data;
    assign bus.res_cout  = r_res_cout;
    assign bus.res_err   = r_res_err;
`ifdef ALU_SEQ_FLAGS_EN
    assign bus.res_zero  = r_res_zero;
    assign bus.res_ovf   = r_res_ovf;
`endif
endmodule
